// File: rtl/random_gen.sv
// rtl/random_gen.sv - parametrised LFSR random source with rejection-sampled draws
// Optional feature macro: RANDOM_GEN_NO_REPEAT_EN (reject a draw equal to the previous value)
module random_gen #(
  parameter int unsigned      WIDTH        = 7,
  parameter logic [WIDTH-1:0] TAPS         = 7'b1100000,
  parameter int unsigned      MAX_VAL      = 100,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             seed_load,
  input  logic             req,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] random
);

  localparam longint unsigned MAX_STATE = (64'd1 << WIDTH) - 64'd1;
  localparam logic [WIDTH-1:0] MAX_V    = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  generate
    if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
      $error("random_gen: WIDTH must be within 3..32");
    end
    if (MAX_VAL == 0 || 64'(MAX_VAL) > MAX_STATE) begin : g_bad_max_val
      $error("random_gen: MAX_VAL must be within 1..2^WIDTH-1");
    end
    if (SEED_DEFAULT == '0) begin : g_bad_seed
      $error("random_gen: SEED_DEFAULT must be nonzero");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] random_q, random_d;
  logic             valid_q, valid_d;
  logic             accept;

  // Entropy counter and LFSR next state: seeding overrides the step, zero never persists
  always_comb begin
    cnt_d = cnt_q + ONE;
    if (seed_load) begin
      lfsr_d = (cnt_q == '0) ? SEED_DEFAULT : cnt_q;
    end else if (lfsr_q == '0) begin
      lfsr_d = SEED_DEFAULT;
    end else begin
      lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
    end
  end

  // Acceptance test for the current LFSR state during a draw
  always_comb begin
    accept = (lfsr_q != '0) && (lfsr_q <= MAX_V);
`ifdef RANDOM_GEN_NO_REPEAT_EN
    if (MAX_VAL != 1) begin
      accept = accept && (lfsr_q != random_q);
    end
`endif
  end

  // Draw FSM: IDLE waits for req, DRAW keeps testing the LFSR until a value is accepted
  always_comb begin
    state_d  = state_q;
    random_d = random_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = DRAW;
        end
      end
      DRAW: begin
        if (accept) begin
          random_d = lfsr_q;
          valid_d  = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      lfsr_q   <= SEED_DEFAULT;
      random_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      random_q <= random_d;
      valid_q  <= valid_d;
    end
  end

  assign busy   = (state_q == DRAW);
  assign valid  = valid_q;
  assign random = random_q;

endmodule
